// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
// Shared definitions for the RAM request/response controller:
//   - default address/data widths and RAM depth
//   - FSM state encodings (plain localparam constants)
//   - addr_in_range(): range check used when a request is accepted
// Optional feature macro: RAM_CTRL_CLEAR_EN (ST_CLEAR is only reachable when it is defined).
package ram_ctrl_pkg;

    localparam int ADDR_W_DEFAULT = 8;
    localparam int DATA_W_DEFAULT = 8;
    localparam int DEPTH_DEFAULT  = 64;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE         = 3'd0;
    localparam logic [STATE_W-1:0] ST_WRITE        = 3'd1;
    localparam logic [STATE_W-1:0] ST_READ_ADDR    = 3'd2;
    localparam logic [STATE_W-1:0] ST_READ_CAPTURE = 3'd3;
    localparam logic [STATE_W-1:0] ST_ERROR        = 3'd4;
    localparam logic [STATE_W-1:0] ST_CLEAR        = 3'd5;

    // The address is zero-extended to 32 bits so one helper serves any width up to 32.
    function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
        return addr < 32'(depth);
    endfunction

endpackage

// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if
// Core-side request/response handshake of ram_ctrl.
//   reqValid/reqReady/reqWrite/reqAddress/reqData : request channel (core -> controller)
//   rspValid/rspData/rspError                     : one-cycle response pulse (controller -> core)
//   busy                                          : controller not idle
// Modports: master (core side), slave (controller side).
interface ram_ctrl_if #(
    parameter int addressWidth = 8,
    parameter int dataWidth    = 8
);
    logic                    reqValid;
    logic                    reqReady;
    logic                    reqWrite;
    logic [addressWidth-1:0] reqAddress;
    logic [dataWidth-1:0]    reqData;
    logic                    rspValid;
    logic [dataWidth-1:0]    rspData;
    logic                    rspError;
    logic                    busy;

    modport master (
        output reqValid, reqWrite, reqAddress, reqData,
        input  reqReady, rspValid, rspData, rspError, busy
    );

    modport slave (
        input  reqValid, reqWrite, reqAddress, reqData,
        output reqReady, rspValid, rspData, rspError, busy
    );

endinterface

// File: rtl/ram_ctrl_clear.sv
// ram_ctrl_clear
// Address counter for the post-reset RAM clear sweep.
// Ports:
//   clock, reset   : clock and synchronous active-high reset (counter returns to 0)
//   i_advance      : step to the next address
//   o_addr         : address currently being cleared
//   o_last         : o_addr is the final location (dataDepth-1)
// The module only exists when RAM_CTRL_CLEAR_EN is defined; the default build has no clear
// sweep, so the file is empty there and leaves no orphan top-level module behind.
`ifdef RAM_CTRL_CLEAR_EN
module ram_ctrl_clear
    import ram_ctrl_pkg::*;
#(
    parameter int addressWidth = ADDR_W_DEFAULT,
    parameter int dataDepth    = DEPTH_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_advance,
    output logic [addressWidth-1:0] o_addr,
    output logic                    o_last
);

    logic [addressWidth-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_advance) begin
            r_count <= r_count + addressWidth'(1);
        end
    end

    assign o_addr = r_count;
    assign o_last = (r_count == addressWidth'(dataDepth - 1));

endmodule
`endif

// File: rtl/ram_ctrl.sv
// ram_ctrl
// Front end for a single-port synchronous RAM. Accepts one read or write at a time from the
// core handshake, sequences the RAM's one-edge write and registered read, captures read data
// and answers out-of-range accesses with an error response.
// Ports:
//   clock, reset        : single clock, synchronous active-high reset
//   core (slave)        : request/response handshake plus busy (see ram_ctrl_if)
//   ramAddress          : RAM address (registered)
//   ramData             : bidirectional RAM data; driven only in WRITE/CLEAR, otherwise high-Z
//   ramSelect/ramWrite/ramOut : RAM strobes (registered)
// Optional feature macro: RAM_CTRL_CLEAR_EN -- after reset the whole RAM is written with zeros
// before the first request is accepted.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int addressWidth = ADDR_W_DEFAULT,
    parameter int dataWidth    = DATA_W_DEFAULT,
    parameter int dataDepth    = DEPTH_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    ram_ctrl_if.slave               core,
    output logic [addressWidth-1:0] ramAddress,
    inout  wire  [dataWidth-1:0]    ramData,
    output logic                    ramSelect,
    output logic                    ramWrite,
    output logic                    ramOut
);

    logic [STATE_W-1:0]      r_state;
    logic [STATE_W-1:0]      w_state_next;

    // Holding registers. The request direction is carried by the state itself, so only the
    // address and write data need to be kept. The address register drives ramAddress directly.
    logic [addressWidth-1:0] r_hold_addr;
    logic [dataWidth-1:0]    r_hold_data;

    logic                    r_ram_select;
    logic                    r_ram_write;
    logic                    r_ram_out;

    logic                    r_rsp_valid;
    logic                    r_rsp_error;
    logic [dataWidth-1:0]    r_rsp_data;
    logic                    r_busy;

    logic                    w_accept;
    logic                    w_in_range;
    logic                    w_drive_bus;
    logic [dataWidth-1:0]    w_bus_out;

`ifdef RAM_CTRL_CLEAR_EN
    localparam logic [STATE_W-1:0] RESET_STATE = ST_CLEAR;

    logic                    w_clear_advance;
    logic [addressWidth-1:0] w_clear_addr;
    logic                    w_clear_last;

    // The first CLEAR cycle after reset only loads the strobes (they are registered and held
    // at 0 by reset); r_ram_select marks that the sweep has started writing.
    assign w_clear_advance = (r_state == ST_CLEAR) && r_ram_select && !w_clear_last;

    ram_ctrl_clear #(
        .addressWidth (addressWidth),
        .dataDepth    (dataDepth)
    ) u_clear (
        .clock     (clock),
        .reset     (reset),
        .i_advance (w_clear_advance),
        .o_addr    (w_clear_addr),
        .o_last    (w_clear_last)
    );

    // Drive only once the write strobe is up, so the bus is never driven without ramWrite.
    assign w_drive_bus = (r_state == ST_WRITE) || ((r_state == ST_CLEAR) && r_ram_select);
    assign w_bus_out   = (r_state == ST_CLEAR) ? '0 : r_hold_data;
`else
    localparam logic [STATE_W-1:0] RESET_STATE = ST_IDLE;

    assign w_drive_bus = (r_state == ST_WRITE);
    assign w_bus_out   = r_hold_data;
`endif

    assign w_accept   = core.reqValid && (r_state == ST_IDLE);
    assign w_in_range = addr_in_range(32'(core.reqAddress), dataDepth);

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_in_range) begin
                        w_state_next = ST_ERROR;
                    end else if (core.reqWrite) begin
                        w_state_next = ST_WRITE;
                    end else begin
                        w_state_next = ST_READ_ADDR;
                    end
                end
            end
            ST_WRITE:        w_state_next = ST_IDLE;
            ST_READ_ADDR:    w_state_next = ST_READ_CAPTURE;
            ST_READ_CAPTURE: w_state_next = ST_IDLE;
            ST_ERROR:        w_state_next = ST_IDLE;
`ifdef RAM_CTRL_CLEAR_EN
            ST_CLEAR: begin
                if (r_ram_select && w_clear_last) begin
                    w_state_next = ST_IDLE;
                end
            end
`endif
            default:         w_state_next = ST_IDLE;
        endcase
    end

    // State, strobes and response registers. Strobes and busy are registered from the next
    // state so that they line up exactly with the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= RESET_STATE;
            r_hold_addr  <= '0;
            r_hold_data  <= '0;
            r_ram_select <= 1'b0;
            r_ram_write  <= 1'b0;
            r_ram_out    <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_error  <= 1'b0;
            r_rsp_data   <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ram_select <= (w_state_next == ST_WRITE) ||
                            (w_state_next == ST_READ_ADDR) ||
                            (w_state_next == ST_READ_CAPTURE);
            r_ram_write  <= (w_state_next == ST_WRITE);
            r_ram_out    <= (w_state_next == ST_READ_ADDR) ||
                            (w_state_next == ST_READ_CAPTURE);
            r_busy       <= (w_state_next != ST_IDLE);
            r_rsp_valid  <= 1'b0;
            r_rsp_error  <= 1'b0;

            if (w_accept) begin
                r_hold_addr <= core.reqAddress;
                r_hold_data <= core.reqData;
            end

            // RAM output register has been loaded at the previous edge; take it now.
            if (r_state == ST_READ_CAPTURE) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= ramData;
            end

            if (r_state == ST_ERROR) begin
                r_rsp_valid <= 1'b1;
                r_rsp_error <= 1'b1;
                r_rsp_data  <= '0;
            end

`ifdef RAM_CTRL_CLEAR_EN
            if (w_state_next == ST_CLEAR) begin
                r_ram_select <= 1'b1;
                r_ram_write  <= 1'b1;
                r_hold_addr  <= r_ram_select ? (w_clear_addr + addressWidth'(1)) : w_clear_addr;
            end
`endif
        end
    end

    assign ramData    = w_drive_bus ? w_bus_out : 'z;
    assign ramAddress = r_hold_addr;
    assign ramSelect  = r_ram_select;
    assign ramWrite   = r_ram_write;
    assign ramOut     = r_ram_out;

    assign core.reqReady = (r_state == ST_IDLE);
    assign core.rspValid = r_rsp_valid;
    assign core.rspError = r_rsp_error;
    assign core.rspData  = r_rsp_data;
    assign core.busy     = r_busy;

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl
// Self-checking bench for ram_ctrl with a behavioural single-port synchronous RAM on the bus.
// Expected responses are queued when a request is accepted and compared when rspValid pulses.
module tb_ram_ctrl;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 64;

    logic          clock;
    logic          reset;
    wire  [DW-1:0] ramData;
    logic [AW-1:0] ramAddress;
    logic          ramSelect;
    logic          ramWrite;
    logic          ramOut;

    ram_ctrl_if #(.addressWidth(AW), .dataWidth(DW)) core ();

    ram_ctrl #(
        .addressWidth (AW),
        .dataWidth    (DW),
        .dataDepth    (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .core       (core),
        .ramAddress (ramAddress),
        .ramData    (ramData),
        .ramSelect  (ramSelect),
        .ramWrite   (ramWrite),
        .ramOut     (ramOut)
    );

    // Behavioural RAM: write on one edge, registered read, drives bus while read-enabled.
    logic [DW-1:0] ram_mem [0:255];
    logic [DW-1:0] ram_q;

    always @(posedge clock) begin
        if (ramSelect && ramWrite) begin
            ram_mem[ramAddress] <= ramData;
        end else if (ramSelect && ramOut) begin
            ram_q <= ram_mem[ramAddress];
        end
    end

    assign ramData = (ramSelect && ramOut && !ramWrite) ? ram_q : 'z;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] shadow [0:DEPTH-1];
    logic          mon_en = 1'b0;
    logic          prev_valid = 1'b0;

    // Response and bus monitor
    always @(negedge clock) begin
        if (!reset && mon_en) begin
            if (core.rspValid) begin
                exp_t e;
                check_eq("rsp_pulse_width", 32'(prev_valid), 32'd0);
                if (sb.size() == 0) begin
                    check_eq("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("rsp_data", 32'(core.rspData), 32'(e.data));
                    check_eq("rsp_error", 32'(core.rspError), 32'(e.err));
                    check_eq("rsp_cycle", 32'(cycle), 32'(e.cyc));
                    $display("rsp: data=0x%02h err=%0b cycle=%0d", core.rspData, core.rspError, cycle);
                end
            end
            if (ramWrite) begin
                check_eq("bus_write_strobes", {30'd0, ramSelect, ramOut}, 32'b10);
            end
`ifndef RAM_CTRL_CLEAR_EN
            check_eq("busy_vs_ready", 32'(core.busy), 32'(!core.reqReady));
`endif
        end
        prev_valid = core.rspValid && !reset;
    end

    // Issue one request and track occupancy; while the controller is busy a decoy request is
    // presented that must be ignored.
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int   guard;
        int   low;
        int   c0;
        exp_t e;
        logic in_range;
        in_range = (addr < AW'(DEPTH));
        guard = 0;
        while (!core.reqReady && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 200) check_eq("ready_timeout", 32'd0, 32'd1);
        core.reqValid   = 1'b1;
        core.reqWrite   = wr;
        core.reqAddress = addr;
        core.reqData    = data;
        @(posedge clock);
        #1;
        c0 = cycle;
        if (!in_range) begin
            e.data = '0; e.err = 1'b1; e.cyc = c0 + 1;
            sb.push_back(e);
        end else if (!wr) begin
            e.data = shadow[addr]; e.err = 1'b0; e.cyc = c0 + 2;
            sb.push_back(e);
        end else begin
            shadow[addr] = data;
        end
        $display("req: %s addr=0x%02h data=0x%02h cycle=%0d", wr ? "WR" : "RD", addr, data, c0);
        @(negedge clock);
        if (!in_range) check_eq("err_no_strobe", 32'(ramSelect), 32'd0);
        low = 0;
        while (!core.reqReady && low < 10) begin
            core.reqValid   = 1'b1;
            core.reqWrite   = 1'b1;
            core.reqAddress = addr ^ AW'(1);
            core.reqData    = ~data;
            low++;
            @(negedge clock);
        end
        core.reqValid = 1'b0;
        check_eq("occupancy", 32'(low), (in_range && !wr) ? 32'd2 : 32'd1);
    endtask

    task automatic drain;
        int g;
        g = 0;
        while (sb.size() != 0 && g < 20) begin
            @(negedge clock);
            g++;
        end
        check_eq("drain_queue_empty", 32'(sb.size()), 32'd0);
    endtask

`ifdef RAM_CTRL_CLEAR_EN
    task automatic count_busy(input int stop_at, output int n);
        int g;
        g = 0;
        n = 0;
        while (!core.busy && g < 10) begin
            @(negedge clock);
            g++;
        end
        while (core.busy && n < 200 && n != stop_at) begin
            n++;
            @(negedge clock);
        end
    endtask
`endif

    initial begin
        int n;
        core.reqValid   = 1'b0;
        core.reqWrite   = 1'b0;
        core.reqAddress = '0;
        core.reqData    = '0;
        reset           = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

`ifdef RAM_CTRL_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        check_eq("clear_ready_low", 32'(core.reqReady), 32'd0);
        count_busy(20, n);
        check_eq("clear_partial", 32'(n), 32'd20);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        count_busy(-1, n);
        check_eq("clear_busy_cycles", 32'(n), 32'(DEPTH));
        check_eq("clear_done_ready", 32'(core.reqReady), 32'd1);
        mon_en = 1'b1;
        issue(1'b0, 8'h3F, 8'h00);
        drain();
`else
        @(negedge clock);
        check_eq("reset_reqReady", 32'(core.reqReady), 32'd1);
        check_eq("reset_busy", 32'(core.busy), 32'd0);
        check_eq("reset_rspValid", 32'(core.rspValid), 32'd0);
        check_eq("reset_ramSelect", 32'(ramSelect), 32'd0);
        check_eq("reset_ramAddress", 32'(ramAddress), 32'd0);
        mon_en = 1'b1;

        // Reset held two cycles in the middle of a read: the read must vanish.
        core.reqValid   = 1'b1;
        core.reqWrite   = 1'b0;
        core.reqAddress = 8'h05;
        @(negedge clock);
        core.reqValid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_eq("midrd_rspValid", 32'(core.rspValid), 32'd0);
        check_eq("midrd_ramSelect", 32'(ramSelect), 32'd0);
        check_eq("midrd_ramWrite", 32'(ramWrite), 32'd0);
        check_eq("midrd_reqReady", 32'(core.reqReady), 32'd1);
        @(negedge clock);
        check_eq("midrd_no_late_rsp", 32'(core.rspValid), 32'd0);
`endif

        // Single write then read back
        issue(1'b1, 8'h10, 8'hA5);
        issue(1'b0, 8'h10, 8'h00);
        drain();

        // Fill the whole RAM with data=address, then read everything back
        for (int a = 0; a < DEPTH; a++) issue(1'b1, AW'(a), DW'(a));
        for (int a = 0; a < DEPTH; a++) issue(1'b0, AW'(a), 8'h00);
        drain();

        // Out-of-range reads and writes
        issue(1'b0, 8'h40, 8'h00);
        issue(1'b1, 8'h40, 8'h77);
        issue(1'b0, 8'hFF, 8'h00);
        drain();

        // Mixed random traffic
        for (int k = 0; k < 40; k++) begin
            issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 71)), DW'($urandom));
        end
        drain();

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule
